// File: rtl/time_of_day.sv
// time_of_day: time-of-day core for the digital clock datapath.
//
// Keeps the time in canonical 24-hour form (h24:m:s), advanced once every
// DIV clock cycles by an internal prescaler while run=1. Set mode zeroes the
// seconds and prescaler and lets inc_hrs / inc_mins adjust hours and minutes.
// The displayed hour and PM flag are derived combinationally from h24, so the
// 12/24-hour display mode can change at any time without touching state.
//
// Parameters:
//   DIV        clk cycles per second (>= 1)
//   RESET_HOUR canonical hour (0-23) loaded on reset
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   run       in   1 = timekeeping advances, 0 = prescaler and time frozen
//   set       in   1 = adjust mode (seconds and prescaler held at 0)
//   inc_hrs   in   hour +1 mod 24 per cycle while set=1
//   inc_mins  in   minute +1 mod 60 per cycle while set=1 (no carry)
//   mode24    in   1 = 24-hour display, 0 = 12-hour display
//   hrs       out  display hour: 0-23 (24h) or 1-12 (12h)
//   mins      out  minutes 0-59
//   secs      out  seconds 0-59
//   pm        out  1 when canonical hour >= 12
//   tick      out  one-cycle pulse after every one-second advance
//   rollover  out  one-cycle pulse after the 23:59:59 -> 00:00:00 advance
//
// Optional feature (macro TIME_OF_DAY_ALARM_EN):
//   alarm_wr      in   load alarm register from alarm_h24_in / alarm_m_in
//   alarm_h24_in  in   canonical alarm hour
//   alarm_m_in    in   alarm minute
//   alarm         out  one-cycle pulse, aligned with tick, when an advance
//                      lands on alarm_h24:alarm_m:00

module time_of_day #(
    parameter int DIV        = 50_000_000,
    parameter int RESET_HOUR = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       set,
    input  logic       inc_hrs,
    input  logic       inc_mins,
    input  logic       mode24,
`ifdef TIME_OF_DAY_ALARM_EN
    input  logic       alarm_wr,
    input  logic [4:0] alarm_h24_in,
    input  logic [5:0] alarm_m_in,
    output logic       alarm,
`endif
    output logic [4:0] hrs,
    output logic [5:0] mins,
    output logic [5:0] secs,
    output logic       pm,
    output logic       tick,
    output logic       rollover
);

    // A single-bit prescaler is kept for DIV=1; it then never leaves 0.
    localparam int            PW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] P_ZERO = PW'(0);
    localparam logic [PW-1:0] P_ONE  = PW'(1);
    localparam logic [4:0]    H_RST  = 5'(RESET_HOUR);

    logic [PW-1:0] p_r, p_s;
    logic [4:0]    h_r, h_s, h_inc_s;
    logic [5:0]    m_r, m_s, m_inc_s;
    logic [5:0]    s_r, s_s, s_inc_s;
    logic          tick_r, tick_s;
    logic          roll_r, roll_s;
    logic          adv_s;
    logic          s_wrap_s, m_wrap_s, h_wrap_s;
    logic [4:0]    hrs_s;

    assign s_wrap_s = (s_r == 6'd59);
    assign m_wrap_s = (m_r == 6'd59);
    assign h_wrap_s = (h_r == 5'd23);
    assign s_inc_s  = s_wrap_s ? 6'd0 : (s_r + 6'd1);
    assign m_inc_s  = m_wrap_s ? 6'd0 : (m_r + 6'd1);
    assign h_inc_s  = h_wrap_s ? 5'd0 : (h_r + 5'd1);

    // Next-state logic: set outranks run; with neither, everything holds.
    always_comb begin
        p_s    = p_r;
        s_s    = s_r;
        m_s    = m_r;
        h_s    = h_r;
        tick_s = 1'b0;
        roll_s = 1'b0;
        adv_s  = 1'b0;
        if (set) begin
            p_s = P_ZERO;
            s_s = 6'd0;
            if (inc_hrs) begin
                h_s = h_inc_s;
            end else begin
                h_s = h_r;
            end
            if (inc_mins) begin
                m_s = m_inc_s;
            end else begin
                m_s = m_r;
            end
        end else if (run) begin
            if (p_r == P_LAST) begin
                p_s    = P_ZERO;
                adv_s  = 1'b1;
                tick_s = 1'b1;
                s_s    = s_inc_s;
                if (s_wrap_s) begin
                    m_s = m_inc_s;
                end else begin
                    m_s = m_r;
                end
                if (s_wrap_s && m_wrap_s) begin
                    h_s = h_inc_s;
                end else begin
                    h_s = h_r;
                end
                roll_s = s_wrap_s && m_wrap_s && h_wrap_s;
            end else begin
                p_s = p_r + P_ONE;
            end
        end else begin
            p_s = p_r;
        end
    end

    // Time, prescaler and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_r    <= P_ZERO;
            s_r    <= 6'd0;
            m_r    <= 6'd0;
            h_r    <= H_RST;
            tick_r <= 1'b0;
            roll_r <= 1'b0;
        end else begin
            p_r    <= p_s;
            s_r    <= s_s;
            m_r    <= m_s;
            h_r    <= h_s;
            tick_r <= tick_s;
            roll_r <= roll_s;
        end
    end

    // Display hour: 12-hour mode maps 0 -> 12 and 13..23 -> 1..11.
    always_comb begin
        hrs_s = h_r;
        if (mode24) begin
            hrs_s = h_r;
        end else if (h_r == 5'd0) begin
            hrs_s = 5'd12;
        end else if (h_r > 5'd12) begin
            hrs_s = h_r - 5'd12;
        end else begin
            hrs_s = h_r;
        end
    end

    assign hrs      = hrs_s;
    assign mins     = m_r;
    assign secs     = s_r;
    assign pm       = (h_r >= 5'd12);
    assign tick     = tick_r;
    assign rollover = roll_r;

`ifdef TIME_OF_DAY_ALARM_EN
    logic [4:0] al_h_r;
    logic [5:0] al_m_r;
    logic       alarm_r;
    logic       al_hit_s;

    // The advance lands on hh:mm:00 only when seconds wrap; compare the
    // post-advance minute and hour against the alarm setting.
    assign al_hit_s = s_wrap_s && (m_inc_s == al_m_r) &&
                      ((m_wrap_s ? h_inc_s : h_r) == al_h_r);

    // Alarm setting register and alarm pulse; adv_s is never set in set mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            al_h_r  <= 5'd0;
            al_m_r  <= 6'd0;
            alarm_r <= 1'b0;
        end else begin
            if (alarm_wr) begin
                al_h_r <= alarm_h24_in;
                al_m_r <= alarm_m_in;
            end else begin
                al_h_r <= al_h_r;
                al_m_r <= al_m_r;
            end
            alarm_r <= adv_s && al_hit_s;
        end
    end

    assign alarm = alarm_r;
`endif

endmodule
